// File: rtl/axi_pkg.sv
// Shared AXI encodings for the read-side responder: burst types, response codes
// and the AR legality check.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Narrow transfers and WRAP/reserved bursts are answered with SLVERR beats.
    function automatic logic ar_is_err(input logic [2:0] size,
                                       input logic [2:0] size_full,
                                       input logic [1:0] burst);
        return (size != size_full) || burst[1];
    endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// Single-clock show-ahead FIFO used as the AR command queue.
// DEPTH must be a power of two so the pointers wrap naturally.
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW:0]      cnt_r;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (cnt_r == FULL_CNT);
    assign empty  = (cnt_r == '0);
    assign count  = cnt_r;
    assign dout   = mem_r[rd_ptr_r];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            cnt_r <= cnt_r + (PW+1)'(push_s) - (PW+1)'(pop_s);
        end
    end

endmodule

// File: rtl/axi_rd_slave_resp.sv
// AXI read responder: queues AR commands and streams R beats from a 1-cycle SRAM,
// with a 2-entry R buffer guarded by a read credit so no returning data is dropped.
module axi_rd_slave_resp
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_MAX_WIDTH = 16,
    parameter int MEM_AW       = 12,
    parameter int CMD_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_MAX_WIDTH-1:0] arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic [1:0]              arlock,
    input  logic [3:0]              arcache,
    input  logic [2:0]              arprot,
    input  logic [3:0]              arqos,
    input  logic [3:0]              arregion,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_MAX_WIDTH-1:0] rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    mem_rd_en,
    output logic [MEM_AW-1:0]       mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int CW    = $clog2(CMD_DEPTH) + 1;

    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0] id;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [3:0]              len;
        logic                    err;
        logic                    fixed;
    } ar_cmd_t;

    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0]   data;
        logic [1:0]              resp;
        logic                    last;
    } r_beat_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    ar_cmd_t                 cmd_in_s;
    ar_cmd_t                 cmd_out_s;
    logic                    cmd_push_s;
    logic                    cmd_pop_s;
    logic                    cmd_full_s;
    logic                    cmd_empty_s;
    logic [CW-1:0]           cmd_count_s;
    logic [CW-1:0]           cmd_cnt_nxt_s;
    logic                    arready_r;

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [3:0]              len_r;
    logic [3:0]              beat_r;
    logic [ID_MAX_WIDTH-1:0] id_r;
    logic                    err_r;
    logic                    fixed_r;
    logic                    last_beat_s;
    logic                    credit_s;
    logic                    issue_s;

    logic                    s2_v_r;
    logic [ID_MAX_WIDTH-1:0] s2_id_r;
    logic                    s2_last_r;
    logic                    s2_err_r;

    r_beat_t                 rbuf_r [2];
    r_beat_t                 wr_beat_s;
    logic                    rb_wr_r;
    logic                    rb_rd_r;
    logic [1:0]              rb_cnt_r;
    logic                    r_pop_s;
    logic                    unused_s;

    assign unused_s = ^{arlock, arcache, arprot, arqos, arregion, addr_r, cmd_full_s};

    // AR capture: legality is decided once here and travels with the command.
    always_comb begin
        cmd_in_s       = '0;
        cmd_in_s.id    = arid;
        cmd_in_s.addr  = araddr;
        cmd_in_s.len   = arlen;
        cmd_in_s.err   = ar_is_err(arsize, 3'(BSH), arburst);
        cmd_in_s.fixed = (arburst == BURST_FIXED);
    end

    assign cmd_push_s    = arvalid && arready_r;
    assign cmd_cnt_nxt_s = cmd_count_s + CW'(cmd_push_s) - CW'(cmd_pop_s);
    assign arready       = arready_r;

    axi_sync_fifo #(
        .WIDTH ($bits(ar_cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_push_s),
        .pop   (cmd_pop_s),
        .din   (cmd_in_s),
        .dout  (cmd_out_s),
        .full  (cmd_full_s),
        .empty (cmd_empty_s),
        .count (cmd_count_s)
    );

    // arready reflects the queue level after this cycle's push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arready_r <= 1'b0;
        end else begin
            arready_r <= (cmd_cnt_nxt_s != CW'(CMD_DEPTH));
        end
    end

    assign r_pop_s     = rvalid && rready;
    assign last_beat_s = (beat_r == len_r);
    // Room for one more beat once buffered + returning data, minus this cycle's pop, is counted.
    assign credit_s    = ({1'b0, rb_cnt_r} + {2'b00, s2_v_r} - {2'b00, r_pop_s}) < 3'd2;

    // Burst FSM: pops a command when idle or right as the previous burst's last beat issues.
    always_comb begin
        state_nxt_s = state_r;
        cmd_pop_s   = 1'b0;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!cmd_empty_s) begin
                    cmd_pop_s   = 1'b1;
                    state_nxt_s = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                issue_s = credit_s;
                if (credit_s && last_beat_s) begin
                    if (!cmd_empty_s) begin
                        cmd_pop_s   = 1'b1;
                        state_nxt_s = ST_BURST;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Active burst context: load on pop, advance on each issued beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r  <= '0;
            len_r   <= 4'd0;
            beat_r  <= 4'd0;
            id_r    <= '0;
            err_r   <= 1'b0;
            fixed_r <= 1'b0;
        end else if (cmd_pop_s) begin
            addr_r  <= cmd_out_s.addr;
            len_r   <= cmd_out_s.len;
            beat_r  <= 4'd0;
            id_r    <= cmd_out_s.id;
            err_r   <= cmd_out_s.err;
            fixed_r <= cmd_out_s.fixed;
        end else if (issue_s) begin
            beat_r <= beat_r + 4'd1;
            if (!fixed_r) begin
                addr_r <= addr_r + ADDR_WIDTH'(BYTES);
            end
        end
    end

    assign mem_rd_en   = issue_s && !err_r && rst_n;
    assign mem_rd_addr = addr_r[MEM_AW+BSH-1:BSH];

    // Error beats follow the same one-cycle slot as SRAM reads so ordering is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            s2_id_r   <= '0;
            s2_last_r <= 1'b0;
            s2_err_r  <= 1'b0;
        end else begin
            s2_v_r    <= issue_s;
            s2_id_r   <= id_r;
            s2_last_r <= last_beat_s;
            s2_err_r  <= err_r;
        end
    end

    // Beat assembled from the returning SRAM word.
    always_comb begin
        wr_beat_s      = '0;
        wr_beat_s.id   = s2_id_r;
        wr_beat_s.last = s2_last_r;
        if (s2_err_r) begin
            wr_beat_s.data = '0;
            wr_beat_s.resp = RESP_SLVERR;
        end else begin
            wr_beat_s.data = mem_rd_data;
            wr_beat_s.resp = RESP_OKAY;
        end
    end

    // Two-entry R buffer; entries are held untouched until their handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rbuf_r[0] <= '0;
            rbuf_r[1] <= '0;
            rb_wr_r   <= 1'b0;
            rb_rd_r   <= 1'b0;
            rb_cnt_r  <= 2'd0;
        end else begin
            if (s2_v_r) begin
                rbuf_r[rb_wr_r] <= wr_beat_s;
                rb_wr_r         <= ~rb_wr_r;
            end
            if (r_pop_s) begin
                rb_rd_r <= ~rb_rd_r;
            end
            rb_cnt_r <= rb_cnt_r + {1'b0, s2_v_r} - {1'b0, r_pop_s};
        end
    end

    assign rvalid = rst_n && (rb_cnt_r != 2'd0);
    assign rid    = rbuf_r[rb_rd_r].id;
    assign rdata  = rbuf_r[rb_rd_r].data;
    assign rresp  = rbuf_r[rb_rd_r].resp;
    assign rlast  = rbuf_r[rb_rd_r].last;

endmodule

// File: tb/tb_axi_rd_slave_resp.sv
// Directed bench for axi_rd_slave_resp: SRAM model, R-beat collector with
// stall-stability checks, and hand-computed expectations per scenario.
module tb_axi_rd_slave_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid;
    logic        arready;
    logic [15:0] arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic [3:0]  arregion;
    logic        rvalid;
    logic        rready;
    logic [15:0] rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        mem_rd_en;
    logic [11:0] mem_rd_addr;
    logic [31:0] mem_rd_data = 32'h0;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        logic [15:0] id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        int          cyc;
    } beat_t;

    beat_t       beats[$];
    logic [11:0] mem_log[$];
    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    axi_rd_slave_resp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arvalid     (arvalid),
        .arready     (arready),
        .arid        (arid),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .arburst     (arburst),
        .arlock      (arlock),
        .arcache     (arcache),
        .arprot      (arprot),
        .arqos       (arqos),
        .arregion    (arregion),
        .rvalid      (rvalid),
        .rready      (rready),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data)
    );

    function automatic logic [31:0] exp_word(input int w);
        return 32'hC0DE_0000 | 32'(w & 4095);
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = exp_word(i);
    end

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beat collector, SRAM-read log, and R stability while stalled.
    logic        prev_stall = 1'b0;
    logic [50:0] prev_beat  = '0;
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) beats.push_back('{rid, rdata, rresp, rlast, cyc});
        if (mem_rd_en) mem_log.push_back(mem_rd_addr);
        if (rst_n && prev_stall) begin
            check_val("stall_rvalid", 64'(rvalid), 64'(1));
            check_val("stall_beat", 64'({rid, rdata, rresp, rlast}), 64'(prev_beat));
        end
        prev_stall = rst_n && rvalid && !rready;
        prev_beat  = {rid, rdata, rresp, rlast};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input logic [15:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int max_wait,
                           output bit acc);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < max_wait && !acc; k++) begin
            @(negedge clk);
            if (arready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int k = 0;
        while (beats.size() < n && k < 600) begin
            tick();
            k++;
        end
        check_val({tag, "_count"}, 64'(beats.size()), 64'(n));
    endtask

    task automatic check_burst(input string tag, input int base, input logic [15:0] id,
                               input int word0, input int n, input bit fixed, input bit err);
        for (int i = 0; i < n; i++) begin
            logic [31:0] ed;
            ed = err ? 32'h0 : exp_word(fixed ? word0 : word0 + i);
            check_val({tag, "_id"},   64'(beats[base+i].id),   64'(id));
            check_val({tag, "_data"}, 64'(beats[base+i].data), 64'(ed));
            check_val({tag, "_resp"}, 64'(beats[base+i].resp), err ? 64'(2) : 64'(0));
            check_val({tag, "_last"}, 64'(beats[base+i].last), 64'(i == n - 1));
        end
    endtask

    task automatic clear_logs();
        beats.delete();
        mem_log.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int lat;
        int nb;
        rst_n = 1'b0; rready = 1'b0; arvalid = 1'b0;
        arid = 16'h0; araddr = 32'h0; arlen = 4'h0; arsize = 3'd2; arburst = 2'b01;
        arlock = 2'b0; arcache = 4'b0; arprot = 3'b0; arqos = 4'b0; arregion = 4'b0;
        repeat (3) tick();

        check_val("rst_arready", 64'(arready), 64'(0));
        check_val("rst_rvalid", 64'(rvalid), 64'(0));
        check_val("rst_mem_rd_en", 64'(mem_rd_en), 64'(0));
        check_val("rst_rbeat", 64'({rid, rdata, rresp, rlast}), 64'(0));
        check_val("rst_mem_rd_addr", 64'(mem_rd_addr), 64'(0));
        rst_n = 1'b1;
        tick();
        check_val("rel_arready", 64'(arready), 64'(1));

        // INCR 4 beats from 0x100: words 0x40..0x43, first rvalid 3 cycles after AR.
        rready = 1'b1;
        clear_logs();
        send_ar(16'h00A1, 32'h100, 4'd3, 3'd2, 2'b01, 10, acc);
        check_val("t1_acc", 64'(acc), 64'(1));
        lat = 0;
        while (!rvalid && lat < 20) begin
            tick();
            lat++;
        end
        check_val("t1_latency", 64'(lat), 64'(3));
        wait_beats(4, "t1");
        check_burst("t1", 0, 16'h00A1, 32'h40, 4, 1'b0, 1'b0);
        check_val("t1_nreads", 64'(mem_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) check_val("t1_maddr", 64'(mem_log[i]), 64'(12'h040 + 12'(i)));
        check_val("t1_sustain", 64'(beats[3].cyc - beats[0].cyc), 64'(3));
        repeat (3) tick();

        // FIXED 3 beats at 0x20: all from word 0x08.
        clear_logs();
        send_ar(16'h00B2, 32'h20, 4'd2, 3'd2, 2'b00, 10, acc);
        wait_beats(3, "t2");
        check_burst("t2", 0, 16'h00B2, 32'h08, 3, 1'b1, 1'b0);
        check_val("t2_nreads", 64'(mem_log.size()), 64'(3));
        for (int i = 0; i < 3; i++) check_val("t2_maddr", 64'(mem_log[i]), 64'(12'h008));
        repeat (3) tick();

        // Narrow size, then WRAP: SLVERR beats, no SRAM access.
        clear_logs();
        send_ar(16'h0033, 32'h100, 4'd1, 3'd1, 2'b01, 10, acc);
        wait_beats(2, "t3a");
        check_burst("t3a", 0, 16'h0033, 0, 2, 1'b0, 1'b1);
        repeat (3) tick();
        check_val("t3a_nreads", 64'(mem_log.size()), 64'(0));
        clear_logs();
        send_ar(16'h0034, 32'h100, 4'd1, 3'd2, 2'b10, 10, acc);
        wait_beats(2, "t3b");
        check_burst("t3b", 0, 16'h0034, 0, 2, 1'b0, 1'b1);
        repeat (3) tick();
        check_val("t3b_nreads", 64'(mem_log.size()), 64'(0));

        // Five 4-beat ARs with rready low: the first moves into the burst engine,
        // the other four fill the queue, so all five are taken and arready drops.
        rready = 1'b0;
        clear_logs();
        for (int k = 1; k <= 5; k++) begin
            send_ar(16'(k), 32'(k * 64), 4'd3, 3'd2, 2'b01, 1, acc);
            check_val("t4_acc", 64'(acc), 64'(1));
        end
        check_val("t4_arready_full", 64'(arready), 64'(0));
        repeat (4) tick();
        check_val("t4_arready_hold", 64'(arready), 64'(0));
        check_val("t4_no_beats", 64'(beats.size()), 64'(0));
        rready = 1'b1;
        wait_beats(20, "t4");
        for (int k = 1; k <= 5; k++) check_burst("t4", (k - 1) * 4, 16'(k), k * 16, 4, 1'b0, 1'b0);
        check_val("t4_no_gap", 64'(beats[19].cyc - beats[0].cyc), 64'(19));
        repeat (3) tick();
        check_val("t4_arready_back", 64'(arready), 64'(1));

        // 16-beat INCR with random backpressure.
        clear_logs();
        send_ar(16'h0055, 32'h400, 4'd15, 3'd2, 2'b01, 10, acc);
        for (int k = 0; k < 800 && beats.size() < 16; k++) begin
            tick();
            rready = 1'($urandom_range(0, 1));
        end
        rready = 1'b1;
        repeat (6) tick();
        check_val("t5_count", 64'(beats.size()), 64'(16));
        check_burst("t5", 0, 16'h0055, 32'h100, 16, 1'b0, 1'b0);

        // Reset in the middle of an 8-beat burst, then a fresh AR.
        clear_logs();
        send_ar(16'h0066, 32'h800, 4'd7, 3'd2, 2'b01, 10, acc);
        wait_beats(2, "t6_pre");
        nb = beats.size();
        rst_n = 1'b0;
        tick();
        check_val("t6_rvalid", 64'(rvalid), 64'(0));
        check_val("t6_arready", 64'(arready), 64'(0));
        check_val("t6_mem_rd_en", 64'(mem_rd_en), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check_val("t6_no_beat", 64'(beats.size()), 64'(nb));
        check_val("t6_arready_rel", 64'(arready), 64'(1));
        clear_logs();
        send_ar(16'h0067, 32'h100, 4'd1, 3'd2, 2'b01, 10, acc);
        wait_beats(2, "t6");
        check_burst("t6", 0, 16'h0067, 32'h40, 2, 1'b0, 1'b0);
        repeat (6) tick();
        check_val("t6_no_stale", 64'(beats.size()), 64'(2));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
